pc_fetch_unit: RTL and testbench

Fetch stage of the single-cycle core. Holds the architectural PC register, fetches the instruction at PC from instruction memory over a req/ack handshake that tolerates wait states, and presents it to decode with a valid/ready handshake. When the core accepts an instruction, the unit loads the next-PC value computed by the NPC stage. It also keeps a retired-instruction counter.

---
 rtl/pc_fetch_unit.sv | 86 ++++++++
 tb/tb_pc_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage: architectural PC, req/ack instruction fetch, valid/ready hand-off to decode.
// Optional misaligned-PC trap is enabled by defining MISALIGN_CHECK_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instret,
    output logic        fault
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0] state;

`ifdef MISALIGN_CHECK_EN
    logic fault_q;
`endif

    // Request and valid are decoded from state so an async reset drops them immediately.
    assign imem_req   = (state == FETCH);
    assign inst_valid = (state == VALID);
    assign imem_addr  = {pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst    <= 32'h0;
            instret <= 32'h0;
`ifdef MISALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        inst  <= imem_rdata;
                        state <= VALID;
                    end
                end
                VALID: begin
                    if (inst_ready) begin
                        pc      <= npc;
                        instret <= instret + 32'd1;
`ifdef MISALIGN_CHECK_EN
                        if (npc[1:0] != 2'b00) begin
                            fault_q <= 1'b1;
                            state   <= HALT;
                        end else begin
                            state <= FETCH;
                        end
`else
                        state <= FETCH;
`endif
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

`ifdef MISALIGN_CHECK_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; delivered instructions are checked by a queue-driven monitor.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instret;
    logic        fault;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] instret;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   done   = 1'b0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instret    (instret),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r);
        exp_t e;
        e.inst = i; e.pc = p; e.instret = r;
        exp_q.push_back(e);
    endtask

    // Monitor: samples 3 time units after each rising edge, pops on every new inst_valid.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (inst_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_inst", inst, e.inst);
                    check("mon_pc", pc, e.pc);
                    check("mon_instret", instret, e.instret);
                end
            end
            prev_valid = inst_valid;
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        if (!done) begin
            $display("FAIL watchdog: got timeout, expected completion");
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        rst_n = 1'b0; npc = 32'h0; inst_ready = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_instret", instret, 32'h0);
        check("rst_fault", {31'd0, fault}, 32'd0);

        // Reset release with immediate ack
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        push(32'h0050_0093, 32'h0, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_req_edge1", {31'd0, imem_req}, 32'd1);
        check("t1_addr_edge1", imem_addr, 32'h0);
        check("t1_valid_edge1", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        check("t1_valid_edge2", {31'd0, inst_valid}, 32'd1);
        check("t1_inst_edge2", inst, 32'h0050_0093);
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;

        // Stall for five cycles, then accept with npc=0x10
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_inst", inst, 32'h0050_0093);
            @(negedge clk);
        end
        inst_ready = 1'b1; npc = 32'h0000_0010;
        @(negedge clk);
        inst_ready = 1'b0; npc = 32'h0;
        check("acc_pc", pc, 32'h10);
        check("acc_instret", instret, 32'd1);
        check("acc_valid", {31'd0, inst_valid}, 32'd0);

        // Three wait states: request/address stable for four FETCH cycles
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
                push(32'h00A0_0113, 32'h10, 32'd1);
            end
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h10);
            check("wait_valid", {31'd0, inst_valid}, 32'd0);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        check("wait_valid_after_ack", {31'd0, inst_valid}, 32'd1);
        check("wait_inst", inst, 32'h00A0_0113);

        // Counter wrap
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        inst_ready = 1'b1; npc = 32'h0000_0014;
        @(negedge clk);
        inst_ready = 1'b0;
        check("wrap_instret", instret, 32'h0);
        check("wrap_pc", pc, 32'h14);
        check("wrap_fault", {31'd0, fault}, 32'd0);
        check("wrap_addr", imem_addr, 32'h14);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        push(32'h0000_0013, 32'h14, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        check("wrap_valid", {31'd0, inst_valid}, 32'd1);

        // Misaligned next PC
        inst_ready = 1'b1; npc = 32'h0000_0006;
        @(negedge clk);
        inst_ready = 1'b0;
        check("mis_pc", pc, 32'h6);
        check("mis_instret", instret, 32'd1);
`ifdef MISALIGN_CHECK_EN
        check("mis_fault", {31'd0, fault}, 32'd1);
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_valid", {31'd0, inst_valid}, 32'd0);
            @(negedge clk);
        end
        imem_ack = 1'b0;
`else
        check("mis_fault", {31'd0, fault}, 32'd0);
        check("mis_req", {31'd0, imem_req}, 32'd1);
        check("mis_addr", imem_addr, 32'h4);
        imem_ack = 1'b1; imem_rdata = 32'h0010_0073;
        push(32'h0010_0073, 32'h6, 32'd1);
        @(negedge clk);
        imem_ack = 1'b0;
        check("mis_valid", {31'd0, inst_valid}, 32'd1);
`endif

        // Reset mid-FETCH with a late ack after release
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rf_req_before", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rf_req_async_drop", {31'd0, imem_req}, 32'd0);
        check("rf_pc", pc, 32'h0);
        check("rf_instret", instret, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("rf_late_ack_valid", {31'd0, inst_valid}, 32'd0);
        check("rf_late_ack_inst", inst, 32'h0);
        check("rf_resume_req", {31'd0, imem_req}, 32'd1);
        check("rf_resume_addr", imem_addr, 32'h0);
        check("rf_fault", {31'd0, fault}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        push(32'h0050_0093, 32'h0, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        check("rf_resume_valid", {31'd0, inst_valid}, 32'd1);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        done = 1'b1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
